// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: receives {addr, cmd_hi, cmd_lo} write transactions.
// SCL/SDA are oversampled on mclk. The 16-bit command is delivered on STOP or on a repeated START.
module i2c_slave_rx #(
    parameter logic [6:0]  SLAVE_ADDRESS = 7'h1A,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic        mclk_in,
    input  logic        reset_n_in,
    input  logic        i2c_clk_in,
    inout  wire         i2c_data_io,
    output logic [15:0] i2c_command_out,
    output logic        i2c_valid_out,
    output logic        i2c_busy_out,
    output logic        i2c_nack_out
);

    localparam int unsigned CHAIN_W = SYNC_STAGES + 1;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CMD_W   = 16;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned IDX_W   = 2;
    localparam logic [BYTE_W-1:0] WRITE_ADDR = {SLAVE_ADDRESS, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_e;

    state_e              state_q, state_d;
    logic [CHAIN_W-1:0]  scl_sync_q, sda_sync_q;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [CMD_W-1:0]    shadow_q, shadow_d;
    logic                word_complete_q, word_complete_d;
    logic                sda_low_q, sda_low_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                nack_q, nack_d;

    logic scl_s, scl_p, sda_s, sda_p;
    logic scl_rise, scl_fall, bus_start, bus_stop;
    logic [BYTE_W-1:0] rx_byte;

    // Input synchronizers; the top bit holds the previous synchronized sample for edge detection.
    always_ff @(posedge mclk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[CHAIN_W-2:0], i2c_clk_in};
            sda_sync_q <= {sda_sync_q[CHAIN_W-2:0], i2c_data_io};
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign scl_p = scl_sync_q[SYNC_STAGES];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign sda_p = sda_sync_q[SYNC_STAGES];

    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign bus_start = scl_s & scl_p & sda_p & ~sda_s;
    assign bus_stop  = scl_s & scl_p & ~sda_p & sda_s;
    assign rx_byte   = {shift_q[BYTE_W-2:0], sda_s};

    // Open-drain SDA: only ever pulled low.
    assign i2c_data_io = sda_low_q ? 1'b0 : 1'bz;

    always_ff @(posedge mclk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            byte_idx_q      <= '0;
            shadow_q        <= '0;
            word_complete_q <= 1'b0;
            sda_low_q       <= 1'b0;
            cmd_q           <= '0;
            valid_q         <= 1'b0;
            busy_q          <= 1'b0;
            nack_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            byte_idx_q      <= byte_idx_d;
            shadow_q        <= shadow_d;
            word_complete_q <= word_complete_d;
            sda_low_q       <= sda_low_d;
            cmd_q           <= cmd_d;
            valid_q         <= valid_d;
            busy_q          <= busy_d;
            nack_q          <= nack_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        byte_idx_d      = byte_idx_q;
        shadow_d        = shadow_q;
        word_complete_d = word_complete_q;
        sda_low_d       = sda_low_q;
        cmd_d           = cmd_q;
        valid_d         = 1'b0;
        busy_d          = busy_q;
        nack_d          = 1'b0;

        if (bus_start || bus_stop) begin
            // Bus conditions override any state; a completed word is delivered here.
            sda_low_d  = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = '0;
            byte_idx_d = '0;
            if (word_complete_q) begin
                cmd_d           = shadow_q;
                valid_d         = 1'b1;
                word_complete_d = 1'b0;
            end
            state_d = bus_start ? ST_ADDR : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = '0;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                            bit_cnt_d = '0;
                            if (rx_byte == WRITE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                                nack_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // First SCL fall after bit 8 pulls SDA low, the next one releases it.
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                            if (state_q == ST_DATA_ACK) begin
                                byte_idx_d = byte_idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
                            bit_cnt_d = '0;
                            if (byte_idx_q == IDX_W'(0)) begin
                                shadow_d[CMD_W-1:BYTE_W] = rx_byte;
                                state_d                  = ST_DATA_ACK;
                            end else if (byte_idx_q == IDX_W'(1)) begin
                                shadow_d[BYTE_W-1:0] = rx_byte;
                                word_complete_d      = 1'b1;
                                state_d              = ST_DATA_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                                nack_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_IGNORE: begin
                    sda_low_d = 1'b0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    assign i2c_command_out = cmd_q;
    assign i2c_valid_out   = valid_q;
    assign i2c_busy_out    = busy_q;
    assign i2c_nack_out    = nack_q;

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C target that receives the 3-byte transactions our codec-control master issues: address byte, then a 16-bit command as two bytes, MSB first.
- Used as an on-chip loopback and verification target for the I2C control path.
- Also usable as the control-port front end of a codec register-file model.
- Oversamples SCL/SDA on the system clock, detects START/STOP, ACKs matching bytes and delivers the 16-bit command with a one-cycle valid strobe.

Parameters:
- SLAVE_ADDRESS, 7'h1A, 7-bit target address; the address byte on the wire for a write is {SLAVE_ADDRESS, 1'b0} = 8'h34.
- SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (minimum 2).

Ports:
- mclk_in  input  1  system clock; must be at least 8x the SCL frequency.
- reset_n_in  input  1  asynchronous, active-low reset.
- i2c_clk_in  input  1  SCL from the bus.
- i2c_data_io  inout  1  SDA, open-drain: driven 0 or high-Z, never driven 1.
- i2c_command_out  output  16  last complete command received.
- i2c_valid_out  output  1  one-cycle pulse when i2c_command_out updates.
- i2c_busy_out  output  1  high between an addressed START and the following STOP/START.
- i2c_nack_out  output  1  one-cycle pulse whenever a byte is NACKed.

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset_n_in low, asynchronous):
  - state=IDLE, SDA released (high-Z).
  - i2c_command_out=16'h0000, i2c_valid_out=0, i2c_busy_out=0, i2c_nack_out=0.
  - Synchronizers preset to 1.
  - Reset mid-transfer releases SDA immediately, even during an ACK, and discards partial data.
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops; edges come from comparing the last two synchronized samples.
  - Pin-to-event latency is SYNC_STAGES+1 mclk cycles.
- Bus events:
  - START: synchronized SDA falls while SCL is high.
  - STOP: synchronized SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge, MSB first.
- States:
  - IDLE: wait for START → ADDR; bit count=0.
  - ADDR: shift 8 bits.
    - Byte == {SLAVE_ADDRESS,0} → ADDR_ACK; busy=1.
    - Otherwise (wrong address or read bit=1) → IGNORE; nack pulse.
  - ADDR_ACK: on the SCL falling edge after bit 8, drive SDA low; on the next SCL falling edge, release → DATA.
  - DATA: shift 8 bits.
    - Byte index 0 loads the shadow high byte; index 1 loads the shadow low byte and sets word_complete.
    - Index ≤1 → DATA_ACK.
    - Index ≥2 → IGNORE without ACK; nack pulse.
  - DATA_ACK: same ACK timing as ADDR_ACK → DATA; byte index increments.
  - IGNORE: SDA released; wait for STOP or START.
- Delivery:
  - On STOP, or on a repeated START, with word_complete=1: i2c_command_out <= shadow, i2c_valid_out=1 for exactly one cycle, then clear word_complete.
  - STOP/START with word_complete=0 (short transfer): no update, no valid.
  - A third data byte is NACKed, but the first two bytes are still delivered at STOP.
- A START or STOP seen in any state overrides everything:
  - Releases SDA.
  - STOP → IDLE; busy=0 in the cycle after STOP.
  - START → ADDR with counters cleared.
- The ACK drive changes SDA only after a synchronized SCL fall, so it can never be misread as a START/STOP by this block.
- The block never stretches SCL and never drives SCL.

Test Plan:
- Write 0x34, 0x09, 0xFF, STOP → ACK low on all three 9th clocks; i2c_command_out=16'h09FF; one valid pulse 3–4 mclk after the STOP edge.
- Address 0x36 followed by two bytes → SDA never driven low; one nack pulse; no valid; command_out keeps its previous value.
- Read address 0x35 → NACK on the address byte; busy stays 0; no valid.
- Write 0x34, 0x12, then STOP → no valid; next full write 0x34,0xAB,0xCD → 16'hABCD.
- Write 0x34,0x01,0x02,0x03,STOP → 3rd byte NACKed (nack pulse); command_out=16'h0102.
- reset_n_in low while SDA is held low during an ACK → SDA high-Z in the same cycle; outputs zero; subsequent write 0x34,0x0F,0x00 → 16'h0F00.
